// File: rtl/fp32_mul_issue.sv
// fp32 multiplier operand-issue FIFO and result-capture stage.
// Flags come from the head operands, independent of the product.
module fp32_mul_issue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_a,
  input  logic [31:0]                in_b,
  output logic [31:0]                mul_a,
  output logic [31:0]                mul_b,
  input  logic [31:0]                mul_product,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_product,
  output logic [2:0]                 out_flags,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [CNT_W-1:0]           result_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LW-1:0] level;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic [31:0]   ha;
  logic [31:0]   hb;
  logic [2:0]    ka;
  logic [2:0]    kb;
  logic          f_nan;
  logic          f_inf;
  logic          f_zero;

  // {nan, inf, zero} of one operand; denormals are not zero
  function automatic logic [2:0] kind(
    input logic [31:0] x
  );
    logic emax;
    logic emin;
    logic mz;
    emax = (x[30:23] == 8'hFF);
    emin = (x[30:23] == 8'h00);
    mz   = (x[22:0] == 23'h0);
    return {emax & !mz, emax & mz, emin & mz};
  endfunction

  assign empty      = (level == '0);
  assign full       = (level == LW'(DEPTH));
  assign in_ready   = !full;
  assign push       = in_valid && in_ready;
  assign pop        = !empty && (!out_valid || out_ready);
  assign fifo_level = level;

  assign ha    = mem[rptr][63:32];
  assign hb    = mem[rptr][31:0];
  assign mul_a = empty ? 32'h0 : ha;
  assign mul_b = empty ? 32'h0 : hb;

  assign ka     = kind(ha);
  assign kb     = kind(hb);
  assign f_nan  = ka[2] | kb[2]
                | (ka[1] & kb[0])
                | (kb[1] & ka[0]);
  assign f_inf  = !f_nan & (ka[1] | kb[1]);
  assign f_zero = !f_nan & !f_inf
                & (ka[0] | kb[0]);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {in_a, in_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case (1'b1)
        (push && !pop): level <= level + 1'b1;
        (pop && !push): level <= level - 1'b1;
        default:        level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_product  <= '0;
      out_flags    <= '0;
      result_count <= '0;
    end else begin
      if (pop) begin
        out_valid   <= 1'b1;
        out_product <= mul_product;
        out_flags   <= {f_nan, f_inf, f_zero};
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready) begin
        result_count <= result_count + 1'b1;
      end
    end
  end

endmodule
